inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 58 +++++
 rtl/inst_fifo.sv | 73 +++++++
 rtl/inst_encoder.sv | 88 ++++++++
 tb/tb_inst_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder_pkg
// Description : Shared types, opcode constants and encode/range helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2,
        FMT_R = 2'd3
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    function automatic logic [31:0] encode(
        input fmt_e        fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        case (fmt)
            FMT_I:   encode = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   encode = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            default: encode = {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    // Out of range means the value is not a sign extension of its legal field width.
    function automatic logic imm_err(input fmt_e fmt, input logic [31:0] imm);
        case (fmt)
            FMT_I, FMT_S: imm_err = (imm[31:11] != {21{imm[11]}});
            FMT_B:        imm_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            default:      imm_err = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo
// Description : Output word FIFO with registered ready and held read data.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    output logic               wr_ready_o,
    input  logic               rd_en_i,
    output logic               rd_valid_o,
    output logic [ENTRY_W-1:0] rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [ENTRY_W-1:0] last_q, last_d;
    logic               push, pop;

    // Ready follows next-cycle occupancy, so a pop during full frees the slot one cycle later.
    always_comb begin
        push     = wr_en_i && ready_q;
        pop      = rd_en_i && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        ready_d  = (cnt_d != FULL_CNT);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // When empty the last popped word stays on the output.
    assign wr_ready_o = ready_q;
    assign rd_valid_o = (cnt_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : last_q;

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Encodes I/S/B/R field bundles into addressed instruction words.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [31:0] in_imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    logic [31:0] addr_q, addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] word_addr;
    logic        accept;
    logic        word_err;
    entry_t      wr_entry;
    entry_t      rd_entry;

    // A reload in the accepting cycle addresses the word itself.
    always_comb begin
        accept    = in_valid && in_ready;
        word_err  = imm_err(fmt_e'(in_fmt), in_imm);
        word_addr = base_load ? base_addr : addr_q;
        addr_d    = accept ? word_addr + 32'd4 : word_addr;
        err_cnt_d = err_cnt_q;
        if (accept && word_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        wr_entry.inst = encode(fmt_e'(in_fmt), in_opcode, in_rd, in_rs1, in_rs2,
                               in_func3, in_func7, in_imm);
        wr_entry.addr = word_addr;
        wr_entry.err  = word_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE;
            err_cnt_q <= 8'd0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (accept),
        .wr_data_i  (wr_entry),
        .wr_ready_o (in_ready),
        .rd_en_i    (out_ready),
        .rd_valid_o (out_valid),
        .rd_data_o  (rd_entry)
    );

    assign out_inst = rd_entry.inst;
    assign out_addr = rd_entry.addr;
    assign out_err  = rd_entry.err;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Scoreboard bench for inst_encoder with a field-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_func3 = '0;
    logic [6:0]  in_func7 = '0;
    logic [31:0] in_imm = '0;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    inst_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [31:0] m_cnt = BASE;
    int          m_err = 0;
    logic        seen_edge = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: place each field at its bit offset with plain arithmetic.
    function automatic logic [31:0] ref_inst(input int fmt, input int unsigned op,
        input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
        input int unsigned f3, input int unsigned f7, input logic [31:0] imm);
        int unsigned u;
        int unsigned w;
        u = imm;
        case (fmt)
            0: w = (u % 4096) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
            1: w = ((u / 32) % 128) * 33554432 + rs2 * 1048576 + rs1 * 32768
                   + f3 * 4096 + (u % 32) * 128 + op;
            2: w = ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432
                   + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + ((u / 2) % 16) * 256
                   + ((u / 2048) % 2) * 128 + op;
            default: w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
                   + rd * 128 + op;
        endcase
        return w;
    endfunction

    function automatic logic ref_err(input int fmt, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (fmt == 0 || fmt == 1) return (s < -2048) || (s > 2047);
        if (fmt == 2) return (s < -4096) || (s > 4094) || ((imm % 2) != 0);
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) seen_edge <= rst_n;

    // Monitor: compare against model state, then retire output and record acceptance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_cnt = BASE;
            m_err = 0;
            last  = '{inst: 32'h0, addr: 32'h0, err: 1'b0};
        end
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
        chk("in_ready", 64'(in_ready), 64'(seen_edge && (sb.size() != DEPTH)));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
            e = sb[0];
            chk("out_inst", 64'(out_inst), 64'(e.inst));
            chk("out_addr", 64'(out_addr), 64'(e.addr));
            chk("out_err", 64'(out_err), 64'(e.err));
            if (out_ready) begin
                void'(sb.pop_front());
                last = e;
            end
        end else if (!out_valid) begin
            chk("hold_inst", 64'(out_inst), 64'(last.inst));
            chk("hold_addr", 64'(out_addr), 64'(last.addr));
            chk("hold_err", 64'(out_err), 64'(last.err));
        end
        if (rst_n && in_valid && in_ready) begin
            e.addr = base_load ? base_addr : m_cnt;
            e.inst = ref_inst(int'(in_fmt), in_opcode, in_rd, in_rs1, in_rs2,
                              in_func3, in_func7, in_imm);
            e.err  = ref_err(int'(in_fmt), in_imm);
            sb.push_back(e);
            m_cnt = e.addr + 32'd4;
            if (e.err && m_err < 255) m_err++;
        end else if (rst_n && base_load) begin
            m_cnt = base_addr;
        end
    end

    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input logic bl, input logic [31:0] ba);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_func3 = f3; in_func7 = 7'($urandom); in_imm = imm;
        base_load = bl; base_addr = ba;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
        base_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        logic [31:0] edges [8];
        edges = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
                  32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_0FFF, 32'h0000_1000};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known encodings
        out_ready = 1'b1;
        send(2'd0, 7'b0010011, 5'd5, 5'd6, 5'd17, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        chk("i_valid", 64'(out_valid), 64'd1);
        chk("i_inst", 64'(out_inst), 64'h0000_0000_FFF3_0293);
        chk("i_addr", 64'(out_addr), 64'd0);
        chk("i_err", 64'(out_err), 64'd0);
        send(2'd1, 7'b0100011, 5'd31, 5'd2, 5'd8, 3'd2, 32'd12, 1'b0, 32'h0);
        chk("s_inst", 64'(out_inst), 64'h0000_0000_0081_2623);
        send(2'd2, 7'b1100011, 5'd9, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 1'b0, 32'h0);
        chk("b_inst", 64'(out_inst), 64'h0000_0000_FE20_8CE3);

        // Reset with queued words
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(2'd0, 7'b0000011, 5'(k), 5'd1, 5'd0, 3'd2, 32'(k * 8), 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_no_emit", 64'(out_valid), 64'd0);

        // Full FIFO with stalled output
        out_ready = 1'b0;
        acc_n = 0;
        in_valid = 1'b1; in_fmt = 2'd3; in_opcode = 7'b0110011; in_func7 = 7'd0;
        for (int k = 0; k < 6; k++) begin
            in_rd = 5'(k); in_rs1 = 5'(k + 1); in_rs2 = 5'(k + 2);
            @(negedge clk);
            if (in_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        chk("full_accepts", 64'(acc_n), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_addr", 64'(out_addr), 64'(k * 4));
            @(posedge clk);
            #1;
        end

        // Range errors and saturation
        do_reset();
        out_ready = 1'b1;
        send(2'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 32'd3, 1'b0, 32'h0);
        chk("b_odd_err", 64'(out_err), 64'd1);
        send(2'd0, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2048, 1'b0, 32'h0);
        chk("i_2048_err", 64'(out_err), 64'd1);
        chk("err_cnt_2", 64'(err_cnt), 64'd2);

        // Reload at the top of the address space
        send(2'd0, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1, 1'b1, 32'hFFFF_FFFC);
        chk("reload_addr", 64'(out_addr), 64'h0000_0000_FFFF_FFFC);
        send(2'd0, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 32'd2, 1'b0, 32'h0);
        chk("wrap_addr", 64'(out_addr), 64'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            base_load = ($urandom_range(0, 19) == 0);
            base_addr = $urandom;
            in_fmt    = 2'($urandom);
            in_opcode = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_func3  = 3'($urandom);
            in_func7  = 7'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       in_imm = $urandom;
                2:       in_imm = edges[$urandom_range(0, 7)];
                default: in_imm = 32'($urandom_range(0, 2047)) * 2;
            endcase
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("queue_empty", 64'(sb.size()), 64'd0);

        // Saturation of the error counter
        in_valid = 1'b1; in_fmt = 2'd0; in_opcode = 7'b0010011; in_imm = 32'd4096;
        repeat (305) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("err_cnt_sat", 64'(err_cnt), 64'd255);
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
